// File: rtl/npc_pkg.sv
// Shared core package: memory access sizes, LSU FSM states and the core's
// instruction-format and ALU-operation enums, plus the byte-lane mask helper.
package npc_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_t;

    typedef enum logic [2:0] {
        INST_R = 3'd0,
        INST_I = 3'd1,
        INST_S = 3'd2,
        INST_B = 3'd3,
        INST_U = 3'd4,
        INST_J = 3'd5
    } inst_type_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    // Byte-enable pattern for an access of the given size, before lane shifting.
    function automatic logic [7:0] size_mask(input mem_size_t sz);
        logic [7:0] m;
        case (sz)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            SZ_D:    m = 8'hFF;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Handshake bundles around the LSU: lsu_req_if (core side) and lsu_mem_if
// (memory side). The LSU is the slave of the former and master of the latter.
interface lsu_req_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    import npc_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    mem_size_t         req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_misalign;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_misalign, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_misalign, resp_err
    );
endinterface

interface lsu_mem_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wstrb;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering for the LSU: store strobe/data shifting into the
// bus word and load extraction with sign or zero extension.
module lsu_align
    import npc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  mem_size_t                   i_size,
    input  logic [$clog2(XLEN/8)-1:0]   i_offset,
    input  logic                        i_unsigned,
    input  logic                        i_we,
    input  logic [XLEN-1:0]             i_wdata,
    input  logic [XLEN-1:0]             i_rdata,
    output logic [XLEN/8-1:0]           o_wstrb,
    output logic [XLEN-1:0]             o_wdata,
    output logic [XLEN-1:0]             o_rdata
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    logic [NB-1:0]      w_mask;
    logic [XLEN-1:0]    w_shift;
    logic [OFF_W+2:0]   w_bitoff;

    always_comb begin
        w_bitoff = {i_offset, 3'b000};
        w_mask   = NB'(size_mask(i_size));
        o_wstrb  = i_we ? (w_mask << i_offset) : '0;
        o_wdata  = i_we ? (i_wdata << w_bitoff) : '0;
    end

    // Loads: bring the addressed bytes down to bit 0, then extend to XLEN.
    always_comb begin
        w_shift = i_rdata >> w_bitoff;
        o_rdata = '0;
        case (i_size)
            SZ_B: o_rdata = i_unsigned ? XLEN'(w_shift[7:0])  : XLEN'($signed(w_shift[7:0]));
            SZ_H: o_rdata = i_unsigned ? XLEN'(w_shift[15:0]) : XLEN'($signed(w_shift[15:0]));
            SZ_W: o_rdata = i_unsigned ? XLEN'(w_shift[31:0]) : XLEN'($signed(w_shift[31:0]));
            SZ_D: o_rdata = w_shift;
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit between the core and a valid/ready memory.
// Optional wait limit enabled by defining LSU_TIMEOUT_EN.
module lsu
    import npc_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    lsu_req_if.slave    core,
    lsu_mem_if.master   mem
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_t         r_state;
    lsu_state_t         w_next;
    logic               r_we;
    mem_size_t          r_size;
    logic               r_unsigned;
    logic [ADDR_W-1:0]  r_addr;
    logic [XLEN-1:0]    r_wdata;
    logic [XLEN-1:0]    r_rdata;
    logic               r_misalign;

    logic               w_misalign;
    logic               w_tmo_hit;
    logic               w_err;
    logic [OFF_W-1:0]   w_offset;
    logic [NB-1:0]      w_wstrb;
    logic [XLEN-1:0]    w_wdata;
    logic [XLEN-1:0]    w_load;

    assign w_offset = r_addr[OFF_W-1:0];

    lsu_align #(.XLEN(XLEN)) u_align (
        .i_size     (r_size),
        .i_offset   (w_offset),
        .i_unsigned (r_unsigned),
        .i_we       (r_we),
        .i_wdata    (r_wdata),
        .i_rdata    (mem.mem_rdata),
        .o_wstrb    (w_wstrb),
        .o_wdata    (w_wdata),
        .o_rdata    (w_load)
    );

    // Doubleword accesses cannot be served by a 32-bit bus at all.
    always_comb begin
        w_misalign = 1'b0;
        case (core.req_size)
            SZ_B:    w_misalign = 1'b0;
            SZ_H:    w_misalign = core.req_addr[0];
            SZ_W:    w_misalign = |core.req_addr[1:0];
            SZ_D:    w_misalign = (XLEN == 32) || (|core.req_addr[2:0]);
            default: w_misalign = 1'b0;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0]   r_tmo;
    logic               r_err;
    logic               w_progress;

    // A handshake or load return arriving on the limit cycle still wins.
    assign w_progress = ((r_state == S_REQ) && mem.mem_req_ready) ||
                        ((r_state == S_WAIT) && mem.mem_rvalid);
    assign w_tmo_hit  = ((r_state == S_REQ) || (r_state == S_WAIT)) &&
                        (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) && !w_progress;
    assign w_err      = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else if ((r_state == S_IDLE) && core.req_valid) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
            r_tmo <= r_tmo + TMO_W'(1);
            if (w_tmo_hit) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_tmo_hit = 1'b0;
    assign w_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (core.req_valid) begin
                    w_next = w_misalign ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (mem.mem_req_ready) begin
                    w_next = r_we ? S_RESP : S_WAIT;
                end else if (w_tmo_hit) begin
                    w_next = S_RESP;
                end
            end
            S_WAIT: begin
                if (mem.mem_rvalid || w_tmo_hit) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request fields are frozen at accept; rdata is cleared so faults report zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we       <= 1'b0;
            r_size     <= SZ_B;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_misalign <= 1'b0;
        end else if ((r_state == S_IDLE) && core.req_valid) begin
            r_we       <= core.req_we;
            r_size     <= core.req_size;
            r_unsigned <= core.req_unsigned;
            r_addr     <= core.req_addr;
            r_wdata    <= core.req_wdata;
            r_rdata    <= '0;
            r_misalign <= w_misalign;
        end else if ((r_state == S_WAIT) && mem.mem_rvalid) begin
            r_rdata    <= w_load;
        end
    end

    always_comb begin
        core.req_ready     = (r_state == S_IDLE);
        core.resp_valid    = (r_state == S_RESP);
        core.resp_rdata    = (r_state == S_RESP) ? r_rdata : '0;
        core.resp_misalign = (r_state == S_RESP) && r_misalign;
        core.resp_err      = (r_state == S_RESP) && w_err;
        mem.mem_req_valid  = (r_state == S_REQ);
        mem.mem_we         = (r_state == S_REQ) && r_we;
        mem.mem_addr       = (r_state == S_REQ) ? {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
        mem.mem_wdata      = (r_state == S_REQ) ? w_wdata : '0;
        mem.mem_wstrb      = (r_state == S_REQ) ? w_wstrb : '0;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter XLEN, default 32, data width; legal values 32 or 64.
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, memory wait limit; used only when LSU_TIMEOUT_EN is defined.
REQ-004 clk  input  1  sole clock; all state changes on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1 / req_ready  output  1  core request handshake.
REQ-007 req_we  input  1  store (1) or load (0).
REQ-008 req_size  input  2  log2 bytes: 0 byte, 1 half, 2 word, 3 dword.
REQ-009 req_unsigned  input  1  zero-extend load data (lbu/lhu/lwu).
REQ-010 req_addr  input  ADDR_W / req_wdata  input  XLEN  byte address, store data right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-012 resp_rdata  output  XLEN / resp_misalign  output  1 / resp_err  output  1  load data, alignment fault, timeout.
REQ-013 mem_req_valid  output  1 / mem_req_ready  input  1  memory request handshake.
REQ-014 mem_we  output  1 / mem_addr  output  ADDR_W / mem_wdata  output  XLEN / mem_wstrb  output  XLEN/8  memory request fields.
REQ-015 mem_rvalid  input  1 / mem_rdata  input  XLEN  load return.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 IDLE: on req_valid, latch all request fields; if misaligned go to RESP, else go to REQ.
REQ-018 Misaligned means addr mod 2^size != 0, or size 3 with XLEN 32; it SHALL issue no memory access and SHALL give resp_misalign=1 with resp_rdata=0.
REQ-019 REQ: mem_req_valid=1 with all fields stable until mem_req_ready; on handshake a store goes to RESP and a load goes to WAIT.
REQ-020 mem_addr SHALL be addr with the low log2(XLEN/8) bits cleared; offset = those bits.
REQ-021 mem_wstrb = (2^(2^size) − 1) << offset; mem_wdata = req_wdata << (8·offset); both SHALL be 0 for loads.
REQ-022 WAIT: on mem_rvalid, capture (mem_rdata >> 8·offset), truncate to 2^size bytes, sign- or zero-extend per req_unsigned, then go to RESP.
REQ-023 mem_rvalid SHALL be ignored outside WAIT; a same-cycle rvalid with the REQ handshake SHALL be ignored.
REQ-024 RESP: resp_valid=1 for exactly one cycle, then IDLE; resp_rdata, resp_misalign and resp_err SHALL be valid only while resp_valid=1, and 0 otherwise.
REQ-025 Latency with mem_req_ready=1 and rvalid one cycle after handshake: store resp at T+2, load resp at T+3, misaligned resp at T+1 (T = accept cycle).
REQ-026 A new request SHALL be accepted no earlier than the cycle after resp_valid; there is no overlap of requests.

Reset
REQ-027 reset SHALL force IDLE from any state, including mid-REQ and mid-WAIT, and clear latched fields and the timeout counter.
REQ-028 After reset, req_ready=1 and every other output SHALL be 0; in-flight memory returns SHALL be discarded.

Configuration
REQ-029 LSU_TIMEOUT_EN defined: a counter SHALL clear on entry to REQ and increment each cycle in REQ/WAIT; on reaching TIMEOUT_CYCLES, go to RESP with resp_err=1, resp_rdata=0, and drop the request.
REQ-030 LSU_TIMEOUT_EN undefined: no counter, resp_err tied 0, and REQ/WAIT wait indefinitely.

Structure
REQ-031 Shared package npc_pkg SHALL hold mem_size_t (SZ_B, SZ_H, SZ_W, SZ_D) and lsu_state_t; the core's inst/ALU enums SHALL migrate there.
REQ-032 One combinational sub-module lsu_align SHALL perform strobe/wdata lane shifting and load extraction/extension; the FSM stays in lsu.

Verification
REQ-033 XLEN=32, sb addr 0x80000003 wdata 0x000000AB -> mem_addr 0x80000000, wstrb 0x8, wdata 0xAB000000, resp at T+2.
REQ-034 XLEN=32, lh addr 0x80000002, mem_rdata 0x8001FFFF -> resp_rdata 0xFFFF8001; same with lhu -> 0x00008001.
REQ-035 lw addr 0x80000002 -> resp_misalign=1 at T+1, mem_req_valid never asserted.
REQ-036 XLEN=64, ld addr 0x80000008, mem_rdata 0x1122334455667788 -> resp_rdata 0x1122334455667788; mem_addr 0x80000008, wstrb 0x00.
REQ-037 mem_req_ready held 0 for 5 cycles, then 1 -> fields stable throughout, single resp; with LSU_TIMEOUT_EN and TIMEOUT_CYCLES=3 -> resp_err=1 instead.
REQ-038 reset asserted in WAIT, then mem_rvalid=1 -> no resp_valid, req_ready=1 next cycle.
